calc1_port_scheduler: RTL and testbench
=======================================

# calc1_port_scheduler

Front-end scheduler for the calc1 calculator. It accepts two-cycle command/operand requests on four independent requester ports and holds at most one pending request per port. It arbitrates among pending ports for a single shared ALU, one operation in flight at a time. Each ALU result goes back to the originating port as a one-cycle response.

## Interface
- DATA_W, 32, operand/result width
- TAG_W, 2, port tag width (ports 1..4 encoded 0..3)
- DROP_W, 8, width of saturating dropped-command counter
- c_clk  in  1  system clock, all logic on rising edge
- reset  in  [1:7]  synchronous, active-high; only reset[1] used, bits 2..7 ignored
- req_cmd_in[1:4]  in  4 each  per-port command (0 NOP, 1 ADD, 2 SUB, 5 LSH, 6 RSH)
- req_data_in[1:4]  in  DATA_W each  operand1 in cmd cycle, operand2 in following cycle
- out_resp[1:4]  out  2 each  00 none, 01 success, 10 overflow/underflow/invalid cmd, 11 reserved (never driven)
- out_data[1:4]  out  DATA_W each  result, valid only when out_resp != 00
- alu_valid / alu_ready  out / in  1  issue handshake
- alu_cmd, alu_op1, alu_op2, alu_tag  out  4, DATA_W, DATA_W, TAG_W  issued operation
- alu_res_valid, alu_res_data, alu_res_ovf, alu_res_tag  in  1, DATA_W, 1, TAG_W  ALU result
- drop_cnt  out  DROP_W  commands discarded because the port was busy (saturates at all-ones)

## Operation
- Per-port capture:
  - Non-zero req_cmd_in sampled at edge k latches cmd and op1.
  - req_data_in at edge k+1 latches op2 and sets pending.
  - The port is busy from edge k until its response cycle.
  - Commands arriving while busy are ignored and increment drop_cnt.
- Invalid cmd (anything other than 1, 2, 5, 6):
  - Never issued to the ALU.
  - Port drives out_resp=10, out_data=0 one cycle after op2 capture.
- Scheduler FSM, one instance:
  - IDLE: if any valid pending port exists, grant one and go to ISSUE.
  - ISSUE: alu_valid=1 with cmd/op1/op2/tag held stable; on alu_valid&&alu_ready go to WAIT.
  - WAIT: on alu_res_valid go to IDLE and route the result by alu_res_tag.
- Result routing:
  - alu_res_ovf=1 → out_resp=10, out_data=0.
  - Otherwise out_resp=01, out_data=alu_res_data.
- alu_res_valid outside WAIT: ignored.
- Tag mismatch (alu_res_tag ≠ granted tag): result is still delivered to the granted port.
- Responses on different ports may coincide. A port never has two responses at once.

## Timing
- Reset values:
  - All out_resp=00, out_data=0, alu_valid=0, alu_cmd/op1/op2/tag=0, drop_cnt=0.
  - FSM=IDLE, all pending cleared.
  - Round-robin pointer = port 1.
- Reset mid-operation: any in-flight ALU result is discarded. Dropped-command history is lost.
- Earliest issue: cmd at edge k, op2 at k+1, alu_valid high in the cycle after edge k+2.
- Response latency: out_resp asserted in the cycle after alu_res_valid is sampled, for exactly one cycle, then returns to 00.
- A port may present a new command in the cycle immediately after its response cycle.
- alu_valid stays high until accepted. No combinational path from alu_ready to alu_valid.

## Configuration
- CALC1_SCHED_FAIR_EN defined: round-robin grant.
  - Search starts at the port after the last granted one.
  - Pointer advances only on an ISSUE handshake.
- Undefined: fixed priority, port 1 highest, port 4 lowest. Starvation of lower ports is permitted.

## Structure
- calc1_sched_pkg holds:
  - command codes CMD_NOP/ADD/SUB/LSH/RSH
  - response codes RESP_NONE/OK/ERR
  - FSM state enum {IDLE, ISSUE, WAIT}
  - cmd-valid function
- Sub-module calc1_rr_arbiter: 4-bit request vector in, one-hot grant plus encoded tag out. Pointer register gated by an advance input. The fixed-priority variant is selected inside it by the macro.

## Test plan
1. Port 1 ADD, op1 0xFFFF0000, op2 0x0000FFFF; ALU model returns 0xFFFFFFFF, ovf=0, tag 0 → alu_valid at k+2 carrying those operands; out_resp[1]=01, out_data[1]=0xFFFFFFFF for one cycle.
2. All four ports issue SUB in the same cycle, ALU always ready:
   - With FAIR_EN: tags issued 0,1,2,3 in order. Repeating the burst starts from port 1 again, since the pointer wraps to 4→1.
   - Without FAIR_EN: same order. Continuous traffic from port 1 starves port 2.
3. Port 2 cmd 4'h3 → out_resp[2]=10, out_data[2]=0 two cycles after cmd; alu_valid never asserted.
4. Port 3 ADD pending, second ADD on port 3 before its response → drop_cnt=1; exactly one response on port 3.
5. reset[1] high one cycle while in WAIT, then alu_res_valid=1 → no out_resp on any port; all outputs at reset values.
6. ALU returns alu_res_ovf=1 for port 4 LSH → out_resp[4]=10, out_data[4]=0.

Source files
------------

// File: rtl/calc1_sched_pkg.sv
// Shared constants and helpers for the calc1 port scheduler.
package calc1_sched_pkg;

  localparam int NPORT = 4;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_LSH = 4'd5;
  localparam logic [3:0] CMD_RSH = 4'd6;

  localparam logic [1:0] RESP_NONE = 2'b00;
  localparam logic [1:0] RESP_OK   = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b10;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;

  function automatic logic cmd_valid(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_LSH) || (cmd == CMD_RSH);
  endfunction

endpackage

// File: rtl/calc1_rr_arbiter.sv
// Picks one pending port for the shared ALU. CALC1_SCHED_FAIR_EN selects
// round-robin; otherwise fixed priority with port 1 highest.
module calc1_rr_arbiter
  import calc1_sched_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [NPORT-1:0] req,
  input  logic             advance,
  input  logic [1:0]       adv_tag,
  output logic [NPORT-1:0] grant,
  output logic [1:0]       tag,
  output logic             any_grant
);

  logic [1:0] start;
  logic [1:0] idx;

`ifdef CALC1_SCHED_FAIR_EN
  // The search begins just past the port most recently accepted by the ALU.
  always_ff @(posedge clk) begin
    if (reset) begin
      start <= '0;
    end else if (advance) begin
      start <= adv_tag + 2'd1;
    end
  end
`else
  logic unused_fixed;
  assign unused_fixed = ^{clk, reset, advance, adv_tag};
  assign start = '0;
`endif

  always_comb begin
    grant     = '0;
    tag       = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int i = 0; i < NPORT; i++) begin
      idx = start + 2'(i);
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        tag        = idx;
      end
    end
  end

endmodule

// File: rtl/calc1_port_scheduler.sv
// Four-port request capture and single-ALU scheduler for calc1.
// Grant policy comes from calc1_rr_arbiter (CALC1_SCHED_FAIR_EN = round-robin).
module calc1_port_scheduler
  import calc1_sched_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 2,
  parameter int DROP_W = 8
) (
  input  logic              c_clk,
  input  logic [1:7]        reset,
  input  logic [3:0]        req_cmd_in  [1:4],
  input  logic [DATA_W-1:0] req_data_in [1:4],
  output logic [1:0]        out_resp    [1:4],
  output logic [DATA_W-1:0] out_data    [1:4],
  output logic              alu_valid,
  input  logic              alu_ready,
  output logic [3:0]        alu_cmd,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [TAG_W-1:0]  alu_tag,
  input  logic              alu_res_valid,
  input  logic [DATA_W-1:0] alu_res_data,
  input  logic              alu_res_ovf,
  input  logic [TAG_W-1:0]  alu_res_tag,
  output logic [DROP_W-1:0] drop_cnt
);

  logic rst;
  logic unused_in;
  assign rst       = reset[1];
  assign unused_in = ^{reset[2:7], alu_res_tag};

  logic [NPORT-1:0]  wait_op2, pending, err_q, inflight, busy;
  logic [3:0]        cmd_q [NPORT];
  logic [DATA_W-1:0] op1_q [NPORT];
  logic [DATA_W-1:0] op2_q [NPORT];
  state_t            state;
  logic [1:0]        gnt_tag;
  logic [NPORT-1:0]  arb_grant;
  logic [1:0]        arb_tag;
  logic              arb_any;
  logic [2:0]        drops;
  logic [DROP_W:0]   drop_sum;

  // A port stays busy from command capture until its response is registered.
  assign busy      = wait_op2 | pending | err_q | inflight;
  assign alu_valid = (state == ST_ISSUE);

  calc1_rr_arbiter u_arb (
    .clk       (c_clk),
    .reset     (rst),
    .req       (pending),
    .advance   (alu_valid && alu_ready),
    .adv_tag   (gnt_tag),
    .grant     (arb_grant),
    .tag       (arb_tag),
    .any_grant (arb_any)
  );

  always_comb begin
    drops = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (busy[i] && (req_cmd_in[i+1] != CMD_NOP)) begin
        drops = drops + 3'd1;
      end
    end
  end

  assign drop_sum = {1'b0, drop_cnt} + (DROP_W+1)'(drops);

  always_ff @(posedge c_clk) begin
    if (rst) begin
      wait_op2 <= '0;
      pending  <= '0;
      err_q    <= '0;
      inflight <= '0;
      state    <= ST_IDLE;
      gnt_tag  <= '0;
      alu_cmd  <= '0;
      alu_op1  <= '0;
      alu_op2  <= '0;
      alu_tag  <= '0;
      drop_cnt <= '0;
      for (int i = 0; i < NPORT; i++) begin
        out_resp[i+1] <= RESP_NONE;
        out_data[i+1] <= '0;
        cmd_q[i]      <= '0;
        op1_q[i]      <= '0;
        op2_q[i]      <= '0;
      end
    end else begin
      drop_cnt <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
      for (int i = 0; i < NPORT; i++) begin
        out_resp[i+1] <= RESP_NONE;
        out_data[i+1] <= '0;
        if (!busy[i] && (req_cmd_in[i+1] != CMD_NOP)) begin
          wait_op2[i] <= 1'b1;
          cmd_q[i]    <= req_cmd_in[i+1];
          op1_q[i]    <= req_data_in[i+1];
        end
        if (wait_op2[i]) begin
          wait_op2[i] <= 1'b0;
          op2_q[i]    <= req_data_in[i+1];
          if (cmd_valid(cmd_q[i])) pending[i] <= 1'b1;
          else                     err_q[i]   <= 1'b1;
        end
        // Invalid commands never reach the ALU; they answer on their own.
        if (err_q[i]) begin
          err_q[i]      <= 1'b0;
          out_resp[i+1] <= RESP_ERR;
        end
      end

      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            state            <= ST_ISSUE;
            gnt_tag          <= arb_tag;
            pending[arb_tag] <= 1'b0;
            inflight         <= inflight | arb_grant;
            alu_cmd          <= cmd_q[arb_tag];
            alu_op1          <= op1_q[arb_tag];
            alu_op2          <= op2_q[arb_tag];
            alu_tag          <= TAG_W'(arb_tag);
          end
        end
        ST_ISSUE: begin
          if (alu_ready) state <= ST_WAIT;
        end
        ST_WAIT: begin
          // The result belongs to the granted port whatever tag comes back.
          if (alu_res_valid) begin
            state                       <= ST_IDLE;
            inflight[gnt_tag]           <= 1'b0;
            out_resp[int'(gnt_tag) + 1] <= alu_res_ovf ? RESP_ERR : RESP_OK;
            out_data[int'(gnt_tag) + 1] <= alu_res_ovf ? '0 : alu_res_data;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc1_port_scheduler.sv
// Self-checking bench for calc1_port_scheduler: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_calc1_port_scheduler;
  import calc1_sched_pkg::*;

  logic        c_clk = 1'b0;
  logic [1:7]  reset;
  logic [3:0]  req_cmd_in  [1:4];
  logic [31:0] req_data_in [1:4];
  logic [1:0]  out_resp    [1:4];
  logic [31:0] out_data    [1:4];
  logic        alu_valid, alu_ready;
  logic [3:0]  alu_cmd;
  logic [31:0] alu_op1, alu_op2;
  logic [1:0]  alu_tag;
  logic        alu_res_valid;
  logic [31:0] alu_res_data;
  logic        alu_res_ovf;
  logic [1:0]  alu_res_tag;
  logic [7:0]  drop_cnt;

  always #5 c_clk = ~c_clk;

  calc1_port_scheduler dut (
    .c_clk         (c_clk),
    .reset         (reset),
    .req_cmd_in    (req_cmd_in),
    .req_data_in   (req_data_in),
    .out_resp      (out_resp),
    .out_data      (out_data),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_cmd       (alu_cmd),
    .alu_op1       (alu_op1),
    .alu_op2       (alu_op2),
    .alu_tag       (alu_tag),
    .alu_res_valid (alu_res_valid),
    .alu_res_data  (alu_res_data),
    .alu_res_ovf   (alu_res_ovf),
    .alu_res_tag   (alu_res_tag),
    .drop_cnt      (drop_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: per-port status (0 free, 1 awaiting op2, 2 queued,
  // 3 invalid awaiting error reply, 4 owned by ALU) plus the ALU slot.
  int          pst [4];
  logic [3:0]  mcmd [4];
  logic [31:0] mop1 [4];
  logic [31:0] mop2 [4];
  int          alu_phase;
  int          owner;
  int          rr_next;
  logic [1:0]  ex_resp [4];
  logic [31:0] ex_data [4];
  logic        ex_valid;
  logic [3:0]  ex_cmd;
  logic [31:0] ex_op1, ex_op2;
  logic [1:0]  ex_tag;
  int          ex_drop;

  int ready_pct, res_pct, ovf_pct, stray_pct;

  function automatic logic [31:0] aluCalc(logic [3:0] c, logic [31:0] a, logic [31:0] b);
    case (c)
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] randCmd();
    int r;
    r = $urandom_range(0, 13);
    if (r < 10) begin
      case (r % 4)
        0: return 4'd1;
        1: return 4'd2;
        2: return 4'd5;
        default: return 4'd6;
      endcase
    end
    r = $urandom_range(0, 10);
    return (r < 2) ? 4'(3 + r) : 4'(5 + r);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic bumpDrop();
    if (ex_drop < 255) ex_drop++;
  endtask

  task automatic modelEdge();
    int snap [4];
    int cand, first;
    if (reset[1]) begin
      for (int p = 0; p < 4; p++) begin
        pst[p] = 0; ex_resp[p] = 2'b00; ex_data[p] = 32'h0;
      end
      alu_phase = 0; owner = 0; rr_next = 0; ex_drop = 0;
      ex_valid = 0; ex_cmd = 0; ex_op1 = 0; ex_op2 = 0; ex_tag = 0;
      return;
    end
    for (int p = 0; p < 4; p++) begin
      snap[p] = pst[p]; ex_resp[p] = 2'b00; ex_data[p] = 32'h0;
    end
    if (alu_phase == 2) begin
      if (alu_res_valid) begin
        ex_resp[owner] = alu_res_ovf ? 2'b10 : 2'b01;
        ex_data[owner] = alu_res_ovf ? 32'h0 : alu_res_data;
        pst[owner] = 0;
        alu_phase = 0;
      end
    end else if (alu_phase == 1) begin
      if (alu_ready) begin
        alu_phase = 2;
        rr_next = (owner + 1) % 4;
      end
    end else begin
      cand = -1;
`ifdef CALC1_SCHED_FAIR_EN
      first = rr_next;
`else
      first = 0;
`endif
      for (int i = 0; i < 4; i++)
        if (cand < 0 && snap[(first + i) % 4] == 2) cand = (first + i) % 4;
      if (cand >= 0) begin
        owner = cand; alu_phase = 1; pst[cand] = 4;
        ex_cmd = mcmd[cand]; ex_op1 = mop1[cand]; ex_op2 = mop2[cand]; ex_tag = 2'(cand);
      end
    end
    ex_valid = (alu_phase == 1);
    for (int p = 0; p < 4; p++) begin
      case (snap[p])
        0: if (req_cmd_in[p+1] != 4'd0) begin
             pst[p] = 1; mcmd[p] = req_cmd_in[p+1]; mop1[p] = req_data_in[p+1];
           end
        1: begin
             mop2[p] = req_data_in[p+1];
             pst[p] = (mcmd[p] inside {4'd1, 4'd2, 4'd5, 4'd6}) ? 2 : 3;
             if (req_cmd_in[p+1] != 4'd0) bumpDrop();
           end
        3: begin
             ex_resp[p] = 2'b10; pst[p] = 0;
             if (req_cmd_in[p+1] != 4'd0) bumpDrop();
           end
        default: if (req_cmd_in[p+1] != 4'd0) bumpDrop();
      endcase
    end
  endtask

  task automatic checkAll();
    checkOutput("alu_valid", alu_valid, ex_valid);
    checkOutput("alu_cmd", alu_cmd, ex_cmd);
    checkOutput("alu_op1", alu_op1, ex_op1);
    checkOutput("alu_op2", alu_op2, ex_op2);
    checkOutput("alu_tag", alu_tag, ex_tag);
    for (int p = 0; p < 4; p++) begin
      checkOutput($sformatf("out_resp%0d", p + 1), out_resp[p+1], ex_resp[p]);
      checkOutput($sformatf("out_data%0d", p + 1), out_data[p+1], ex_data[p]);
    end
    checkOutput("drop_cnt", drop_cnt, ex_drop);
  endtask

  // ALU stand-in: answers only from the model's own copy of the operands.
  task automatic driveAlu();
    alu_ready = ($urandom_range(0, 99) < ready_pct);
    if (alu_phase == 2 && $urandom_range(0, 99) < res_pct) begin
      alu_res_valid = 1'b1;
      alu_res_ovf   = ($urandom_range(0, 99) < ovf_pct);
      alu_res_data  = aluCalc(mcmd[owner], mop1[owner], mop2[owner]);
      alu_res_tag   = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'(owner);
    end else begin
      alu_res_valid = ($urandom_range(0, 99) < stray_pct);
      alu_res_ovf   = 1'($urandom);
      alu_res_data  = $urandom;
      alu_res_tag   = 2'($urandom);
    end
  endtask

  task automatic applyStimulus();
    driveAlu();
    @(posedge c_clk);
    modelEdge();
    #1;
    checkAll();
    for (int p = 1; p <= 4; p++) begin
      req_cmd_in[p]  = 4'd0;
      req_data_in[p] = $urandom;
    end
    reset[2:7] = 6'($urandom);
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic sendCmd(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    req_cmd_in[p]  = c;
    req_data_in[p] = a;
    applyStimulus();
    req_data_in[p] = b;
    applyStimulus();
  endtask

  initial begin
    ready_pct = 100; res_pct = 100; ovf_pct = 0; stray_pct = 0;
    alu_phase = 0; owner = 0;
    reset = 7'b1000000;
    for (int p = 1; p <= 4; p++) begin
      req_cmd_in[p] = 4'd0; req_data_in[p] = 32'h0;
    end
    settle(2);
    reset[1] = 1'b0;
    settle(2);

    // Single ADD through the ALU
    sendCmd(1, CMD_ADD, 32'hFFFF0000, 32'h0000FFFF);
    settle(6);

    // Simultaneous SUB on all ports, twice
    for (int rep = 0; rep < 2; rep++) begin
      for (int p = 1; p <= 4; p++) begin
        req_cmd_in[p] = CMD_SUB; req_data_in[p] = $urandom;
      end
      applyStimulus();
      for (int p = 1; p <= 4; p++) req_data_in[p] = $urandom;
      applyStimulus();
      settle(16);
    end

    // Invalid command
    sendCmd(2, 4'h3, 32'h1234, 32'h5678);
    settle(4);

    // Second command while busy is dropped
    sendCmd(3, CMD_ADD, 32'd10, 32'd20);
    req_cmd_in[3] = CMD_ADD;
    applyStimulus();
    settle(8);

    // Overflowing shift
    ovf_pct = 100;
    sendCmd(4, CMD_LSH, 32'h8000_0001, 32'd1);
    settle(6);
    ovf_pct = 0;

    // Reset while waiting on the ALU, then a late result
    res_pct = 0;
    sendCmd(1, CMD_ADD, 32'd1, 32'd2);
    for (int i = 0; i < 10 && alu_phase != 2; i++) applyStimulus();
    reset[1] = 1'b1;
    applyStimulus();
    reset[1] = 1'b0;
    stray_pct = 100;
    applyStimulus();
    stray_pct = 0; res_pct = 100;
    settle(3);

    // Randomized traffic with occasional resets
    ready_pct = 70; res_pct = 40; ovf_pct = 20; stray_pct = 10;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int p = 0; p < 4; p++) begin
        if (pst[p] == 0 && $urandom_range(0, 99) < 35) req_cmd_in[p+1] = randCmd();
        else if (pst[p] != 0 && $urandom_range(0, 99) < 4) req_cmd_in[p+1] = randCmd();
      end
      reset[1] = (cyc % 1000 == 999);
      applyStimulus();
    end
    reset[1] = 1'b0;
    settle(2);

    // Drive drop_cnt into saturation while port 1 waits on the ALU
    ready_pct = 100; res_pct = 0; stray_pct = 0;
    settle(12);
    sendCmd(1, CMD_RSH, 32'hF0F0_F0F0, 32'd4);
    for (int i = 0; i < 300; i++) begin
      req_cmd_in[1] = CMD_ADD;
      applyStimulus();
    end
    res_pct = 100;
    settle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
